// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port among NREQ
// requesters, with a two-stage pipeline (read in flight, response register).
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   req_valid      - per-requester read request
//   req_addr       - per-requester word address, requester i at [i*SCALE +: SCALE]
//   req_ready      - grant strobe, one-hot or zero (combinational)
//   resp_valid     - per-requester response valid, decoded from S2 registers
//   resp_data      - shared response word
//   resp_ready     - per-requester response consume
//   mem_oe         - memory read enable (combinational, equals grant)
//   mem_addr       - memory address; holds the last granted address when idle
//   mem_rdata      - memory data, valid one cycle after mem_oe
module rom_port_arbiter #(
  parameter int unsigned SCALE = 10,
  parameter int unsigned NREQ  = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*SCALE-1:0]   req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         resp_valid,
  output logic [31:0]             resp_data,
  input  logic [NREQ-1:0]         resp_ready,
  output logic                    mem_oe,
  output logic [SCALE-1:0]        mem_addr,
  input  logic [31:0]             mem_rdata
);

  localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic             run_q;
  logic             s1_valid;
  logic [IDW-1:0]   s1_id;
  logic             s2_valid;
  logic [IDW-1:0]   s2_id;
  logic [31:0]      s2_data;
  logic [IDW-1:0]   last_grant;
  logic [SCALE-1:0] addr_q;

  logic             found;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   gnt_id;
  logic             gnt;
  logic             stall;
  logic             s2_take;
  logic             s1_adv;
  logic [SCALE-1:0] gnt_addr;

  // Pipeline flow control: S2 drains on consume, S1 moves when S2 is free or draining.
  assign s2_take = s2_valid & resp_ready[s2_id];
  assign s1_adv  = s1_valid & (~s2_valid | s2_take);
  assign stall   = s2_valid & ~resp_ready[s2_id] & s1_valid;

  // Round-robin search starting one past the last grant.
  always_comb begin
    found  = 1'b0;
    idx    = '0;
    gnt_id = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = IDW'((int'(last_grant) + 1 + k) % int'(NREQ));
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        gnt_id = idx;
      end
    end
  end

  // run_q keeps grants off until the first clock edge after reset release.
  assign gnt      = found & run_q & ~stall;
  assign gnt_addr = req_addr[int'(gnt_id)*SCALE +: SCALE];

  always_comb begin
    req_ready = '0;
    if (gnt) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  assign mem_oe   = gnt;
  assign mem_addr = gnt ? gnt_addr : addr_q;

  always_comb begin
    resp_valid = '0;
    if (s2_valid) begin
      resp_valid[s2_id] = 1'b1;
    end
  end

  assign resp_data = s2_data;

  // Arbiter pointer, address hold and pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
      addr_q     <= '0;
      s1_valid   <= 1'b0;
      s1_id      <= '0;
      s2_valid   <= 1'b0;
      s2_id      <= '0;
      s2_data    <= '0;
    end else begin
      run_q <= 1'b1;
      if (gnt) begin
        last_grant <= gnt_id;
        addr_q     <= gnt_addr;
      end
      if (gnt) begin
        s1_valid <= 1'b1;
        s1_id    <= gnt_id;
      end else if (s1_adv) begin
        s1_valid <= 1'b0;
      end
      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_id    <= s1_id;
        s2_data  <= mem_rdata;
      end else if (s2_take) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Bench for rom_port_arbiter: memory model, scoreboard of granted reads,
// arbitration vector table and hand sequences for pipeline corner cases.
module tb_rom_port_arbiter;

  localparam int unsigned SCALE = 10;
  localparam int unsigned NREQ  = 3;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*SCALE-1:0] req_addr;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       resp_valid;
  logic [31:0]           resp_data;
  logic [NREQ-1:0]       resp_ready;
  logic                  mem_oe;
  logic [SCALE-1:0]      mem_addr;
  logic [31:0]           mem_rdata;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [2:0] rv;
    logic [2:0] rr;
    logic [2:0] exp;
  } vec_t;
  vec_t vt [13];

  int checks;
  int failures;

  always #5 clk = ~clk;

  // Synchronous-read memory: data one cycle after mem_oe, held otherwise.
  always @(posedge clk) begin
    if (mem_oe) mem_rdata <= mem[mem_addr];
  end

  rom_port_arbiter #(.SCALE(SCALE), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .resp_ready (resp_ready),
    .mem_oe     (mem_oe),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Grant-side push and response-side pop against the scoreboard.
  task automatic monitor();
    exp_t e;
    if (rst_n) begin
      if (req_ready != '0) begin
        chk("grant_onehot", 32'($onehot(req_ready)), 32'd1);
        for (int i = 0; i < int'(NREQ); i++) begin
          if (req_ready[i]) begin
            chk("grant_oe", 32'(mem_oe), 32'd1);
            chk("grant_addr", 32'(mem_addr), 32'(req_addr[i*SCALE +: SCALE]));
            chk("grant_requested", 32'(req_valid[i]), 32'd1);
            e.id   = 2'(i);
            e.data = mem[req_addr[i*SCALE +: SCALE]];
            sbq.push_back(e);
          end
        end
      end
      if ((resp_valid & resp_ready) != '0) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected: got resp_valid=%b expected none", resp_valid);
        end else begin
          e = sbq.pop_front();
          chk("resp_id", 32'(resp_valid), 32'(3'b001 << e.id));
          chk("resp_data", resp_data, e.data);
        end
      end
    end
  endtask

  task automatic samp();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    samp();
    adv();
  endtask

  task automatic drain(input int n);
    req_valid = '0;
    repeat (n) cyc();
  endtask

  task automatic set_addr(input int a0, input int a1, input int a2);
    req_addr[0*SCALE +: SCALE] = 10'(a0);
    req_addr[1*SCALE +: SCALE] = 10'(a1);
    req_addr[2*SCALE +: SCALE] = 10'(a2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_mem_oe"},     32'(mem_oe),     32'd0);
    chk({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
  endtask

  task automatic do_reset();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("reset");
    chk("reset_resp_data", resp_data, 32'd0);
    sbq.delete();
    adv();
    adv();
    rst_n = 1'b1;
    samp();
    chk("post_reset_no_grant", 32'(req_ready), 32'd0);
    adv();
    req_valid = '0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    resp_ready = 3'b111;
    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) * 32'h9E3779B1 + 32'h1234;
    mem[5] = 32'hDEADBEEF;

    vt[0]  = '{rv: 3'b111, rr: 3'b111, exp: 3'b010};
    vt[1]  = '{rv: 3'b111, rr: 3'b111, exp: 3'b100};
    vt[2]  = '{rv: 3'b111, rr: 3'b111, exp: 3'b001};
    vt[3]  = '{rv: 3'b101, rr: 3'b111, exp: 3'b100};
    vt[4]  = '{rv: 3'b011, rr: 3'b111, exp: 3'b001};
    vt[5]  = '{rv: 3'b100, rr: 3'b111, exp: 3'b100};
    vt[6]  = '{rv: 3'b000, rr: 3'b111, exp: 3'b000};
    vt[7]  = '{rv: 3'b110, rr: 3'b111, exp: 3'b010};
    vt[8]  = '{rv: 3'b010, rr: 3'b111, exp: 3'b010};
    vt[9]  = '{rv: 3'b001, rr: 3'b111, exp: 3'b001};
    vt[10] = '{rv: 3'b110, rr: 3'b111, exp: 3'b010};
    vt[11] = '{rv: 3'b101, rr: 3'b111, exp: 3'b100};
    vt[12] = '{rv: 3'b001, rr: 3'b111, exp: 3'b001};

    #2;
    do_reset();

    // Single read of word 5, two-cycle latency, then address hold.
    set_addr(5, 0, 0);
    req_valid = 3'b001;
    samp();
    chk("single_ready", 32'(req_ready), 32'b001);
    chk("single_oe", 32'(mem_oe), 32'd1);
    chk("single_addr", 32'(mem_addr), 32'd5);
    adv();
    req_valid = '0;
    samp();
    chk("single_t1_resp_valid", 32'(resp_valid), 32'd0);
    adv();
    samp();
    chk("single_t2_resp_valid", 32'(resp_valid), 32'b001);
    chk("single_t2_resp_data", resp_data, 32'hDEADBEEF);
    adv();
    samp();
    chk("idle_mem_oe", 32'(mem_oe), 32'd0);
    chk("idle_mem_addr_hold", 32'(mem_addr), 32'd5);
    adv();

    // Arbitration table, pointer starts at requester 0.
    for (int e = 0; e < 13; e++) begin
      req_valid  = vt[e].rv;
      resp_ready = vt[e].rr;
      set_addr(e*4 + 16, e*4 + 17, e*4 + 18);
      samp();
      chk($sformatf("vec%0d_ready", e), 32'(req_ready), 32'(vt[e].exp));
      adv();
    end
    drain(3);

    // Fairness from reset: 0,1,2,0,1,2 with one response per cycle.
    do_reset();
    resp_ready = 3'b111;
    req_valid  = 3'b111;
    set_addr(100, 101, 102);
    for (int k = 0; k < 6; k++) begin
      samp();
      chk($sformatf("fair%0d_ready", k), 32'(req_ready), 32'(3'b001 << (k % 3)));
      if (k >= 2) chk($sformatf("fair%0d_resp", k), 32'(resp_valid), 32'(3'b001 << ((k - 2) % 3)));
      adv();
    end
    req_valid = '0;
    samp();
    chk("fair6_resp", 32'(resp_valid), 32'b010);
    adv();
    samp();
    chk("fair7_resp", 32'(resp_valid), 32'b100);
    adv();
    drain(2);

    // Backpressure on requester 1 with a withdrawn request from requester 2.
    set_addr(300, 200, 400);
    resp_ready = 3'b101;
    req_valid  = 3'b010;
    samp();
    chk("bp_t0_ready", 32'(req_ready), 32'b010);
    adv();
    req_valid = 3'b001;
    samp();
    chk("bp_t1_ready", 32'(req_ready), 32'b001);
    chk("bp_t1_resp", 32'(resp_valid), 32'd0);
    adv();
    req_valid = 3'b101;
    for (int k = 0; k < 4; k++) begin
      samp();
      chk($sformatf("bp_stall%0d_ready", k), 32'(req_ready), 32'd0);
      chk($sformatf("bp_stall%0d_resp", k), 32'(resp_valid), 32'b010);
      chk($sformatf("bp_stall%0d_data", k), resp_data, mem[200]);
      adv();
    end
    req_valid  = '0;
    resp_ready = 3'b111;
    samp();
    chk("bp_rel_resp1", 32'(resp_valid), 32'b010);
    adv();
    samp();
    chk("bp_rel_resp0", 32'(resp_valid), 32'b001);
    chk("bp_rel_data0", resp_data, mem[300]);
    adv();
    samp();
    chk("bp_rel_empty", 32'(resp_valid), 32'd0);
    adv();
    req_valid = 3'b011;
    samp();
    chk("withdraw_pointer", 32'(req_ready), 32'b010);
    adv();
    drain(3);

    // Reset one cycle after a grant discards the in-flight read.
    set_addr(7, 8, 9);
    req_valid = 3'b001;
    samp();
    chk("rmf_grant", 32'(req_ready), 32'b001);
    adv();
    req_valid = 3'b111;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("rmf");
    sbq.delete();
    adv();
    adv();
    rst_n = 1'b1;
    samp();
    chk("rmf_rel_ready", 32'(req_ready), 32'd0);
    chk("rmf_rel_resp", 32'(resp_valid), 32'd0);
    adv();
    samp();
    chk("rmf_first_grant", 32'(req_ready), 32'b001);
    chk("rmf_rel1_resp", 32'(resp_valid), 32'd0);
    adv();
    req_valid = '0;
    samp();
    chk("rmf_rel2_resp", 32'(resp_valid), 32'd0);
    adv();
    samp();
    chk("rmf_new_resp", 32'(resp_valid), 32'b001);
    chk("rmf_new_data", resp_data, mem[7]);
    adv();
    drain(3);

    chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rom_port_arbiter.md
ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

Interface
REQ-001 Parameter SCALE, default 10, is the word-address width of the shared memory read port.
REQ-002 Parameter NREQ, default 3, is the number of requesters (2..4).
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port req_valid, input, NREQ bits: per-requester read request.
REQ-006 Port req_addr, input, NREQ*SCALE bits: per-requester word address, requester i at bits [i*SCALE +: SCALE].
REQ-007 Port req_ready, output, NREQ bits: request accepted this cycle; one-hot or zero.
REQ-008 Port resp_valid, output, NREQ bits: response data valid for requester i; one-hot or zero.
REQ-009 Port resp_data, output, 32 bits: response word, shared by all requesters.
REQ-010 Port resp_ready, input, NREQ bits: requester i consumes the response.
REQ-011 Port mem_oe, output, 1 bit: memory read enable.
REQ-012 Port mem_addr, output, SCALE bits: memory address.
REQ-013 Port mem_rdata, input, 32 bits: memory data.
REQ-014 mem_rdata SHALL be valid one cycle after mem_oe=1, and SHALL remain stable while mem_oe=0.

Function
REQ-015 The pipeline SHALL have two stages:
- S1: read in flight; holds s1_valid and s1_id.
- S2: response register; holds s2_valid, s2_id and s2_data.
REQ-016 A request SHALL be granted in cycle T only when stall=0.
- stall = s2_valid & ~resp_ready[s2_id] & s1_valid.
REQ-017 On grant:
- req_ready[g]=1 and mem_oe=1.
- mem_addr = req_addr slice g.
- S1 loads valid=1, id=g at the edge.
REQ-018 When no grant occurs, mem_oe SHALL be 0 and mem_addr SHALL hold its last value.
REQ-019 Arbitration SHALL be round-robin:
- Search starts at requester (last_grant+1) mod NREQ.
- last_grant updates only on a grant.
REQ-020 S1 SHALL advance into S2 (s2_data <= mem_rdata) when s1_valid and (~s2_valid or resp_ready[s2_id]).
- Otherwise S1 holds and no grant occurs.
REQ-021 S2 SHALL clear when resp_ready[s2_id]=1 and S1 does not advance in the same cycle.
REQ-022 resp_valid[i] SHALL equal s2_valid & (s2_id==i), driven from registers only.
REQ-023 resp_data SHALL equal s2_data.
REQ-024 Latency and throughput:
- A grant in cycle T yields resp_valid in cycle T+2.
- Sustained throughput is one response per cycle while resp_ready is held high.
REQ-025 resp_ready on a requester that has no valid response SHALL be ignored.
REQ-026 req_valid deasserted while not granted SHALL be legal; a withdrawn request has no effect.
REQ-027 Order: responses SHALL return in grant order; the pipeline never holds more than 2 outstanding reads.

Reset
REQ-028 While rst_n=0, asynchronously:
- s1_valid=0, s2_valid=0, s2_data=0.
- req_ready=0, resp_valid=0, mem_oe=0, mem_addr=0.
- last_grant=NREQ-1, so requester 0 wins first.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight reads; no response is produced for them after release.
REQ-030 The first grant SHALL occur no earlier than the first rising edge with rst_n=1.

Verification
REQ-031 Single read: memory word 5 = 0xDEADBEEF; req_valid=001, addr0=5 at T -> req_ready=001 at T, mem_oe=1 and mem_addr=5 at T, resp_valid=001 and resp_data=0xDEADBEEF at T+2.
REQ-032 Fairness: all three requesters held valid with resp_ready=111 -> grants 0,1,2,0,1,2 on consecutive cycles, one response per cycle.
REQ-033 Backpressure: requester 1 holds resp_ready=0 for 4 cycles while requester 0 keeps requesting:
- Exactly one further grant occurs, then req_ready=000.
- resp_data stays stable.
- After release, both responses are delivered in order and no data is lost.
REQ-034 Withdrawal: requester 2 drops req_valid before being granted -> no response for requester 2, and the round-robin pointer is unchanged.
REQ-035 Reset mid-flight: rst_n driven low in the cycle after a grant -> all outputs are 0 immediately, no resp_valid after release, and the next grant goes to requester 0.
